// File: rtl/add_arbiter.sv
// Shared W-bit adder for NREQ requesters behind a 2-stage (operand, sum) pipeline.
// Define ADD_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index).
module add_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*W-1:0]         req_a,
  input  logic [NREQ*W-1:0]         req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic                      rsp_valid,
  output logic [W:0]                rsp_sum,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  input  logic                      rsp_ready
);
  localparam int IDW = $clog2(NREQ);

  logic           r_s1_v;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [IDW-1:0] r_s1_id;
  logic           r_s2_v;
  logic [W:0]     r_sum;
  logic [IDW-1:0] r_s2_id;

  logic           w_s2_free;
  logic           w_s1_free;
  logic           w_any;
  logic           w_xfer;
  logic [IDW-1:0] w_idx;

`ifdef ADD_ARB_RR_EN
  logic [IDW-1:0] r_ptr;

  // Search starts at the pointer; IDW-bit addition wraps because NREQ is a power of two.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[r_ptr + IDW'(k)]) begin
        w_any = 1'b1;
        w_idx = r_ptr + IDW'(k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_idx + IDW'(1);
    end
  end
`else
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[k]) begin
        w_any = 1'b1;
        w_idx = IDW'(k);
      end
    end
  end
`endif

  assign w_s2_free = !r_s2_v || rsp_ready;
  assign w_s1_free = !r_s1_v || w_s2_free;
  assign w_xfer    = w_any && w_s1_free && !rst;

  always_comb begin
    req_ready = '0;
    if (w_xfer) begin
      req_ready[w_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_s1_id <= '0;
    end else if (w_xfer) begin
      r_s1_v  <= 1'b1;
      r_a     <= req_a[w_idx*W +: W];
      r_b     <= req_b[w_idx*W +: W];
      r_s1_id <= w_idx;
    end else if (w_s1_free) begin
      r_s1_v  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v  <= 1'b0;
      r_sum   <= '0;
      r_s2_id <= '0;
    end else if (w_s2_free) begin
      r_s2_v  <= r_s1_v;
      r_sum   <= {1'b0, r_a} + {1'b0, r_b};
      r_s2_id <= r_s1_id;
    end
  end

  assign rsp_valid = r_s2_v;
  assign rsp_sum   = r_sum;
  assign rsp_id    = r_s2_id;
endmodule

// File: tb/tb_add_arbiter.sv
// Randomized and directed scoreboard bench for add_arbiter; honours ADD_ARB_RR_EN.
module tb_add_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*W-1:0]   req_a;
  logic [NREQ*W-1:0]   req_b;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic [W:0]          rsp_sum;
  logic [IDW-1:0]      rsp_id;
  logic                rsp_ready;

  add_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
    .rsp_ready(rsp_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W:0] sum; int id; } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  bit           pv [NREQ];
  logic [W-1:0] pa [NREQ];
  logic [W-1:0] pb [NREQ];

  bit m_s1v = 0;
  bit m_s2v = 0;
  int m_ptr = 0;
  int last_gnt = -1;
  int dut_gnt = -1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int start);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(start + k) % NREQ]) return (start + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = pv[i];
      req_a[i*W +: W]    = pa[i];
      req_b[i*W +: W]    = pb[i];
    end
  endtask

  // One clock: check outputs against the model at negedge, advance model, return at posedge+1.
  task automatic step();
    logic [NREQ-1:0] vm;
    logic [NREQ-1:0] expr;
    bit s1f, s2f;
    int g, start;
    exp_t e;
    @(negedge clk);
    dut_gnt = -1;
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_gnt = i;
    if (rst) begin
      check("ready_in_reset", 64'(req_ready), 64'(0));
      exp_q.delete();
      m_s1v = 0; m_s2v = 0; m_ptr = 0; last_gnt = -1;
    end else begin
      check("rsp_valid", 64'(rsp_valid), 64'(m_s2v));
      for (int i = 0; i < NREQ; i++) vm[i] = pv[i];
      s2f = !m_s2v || rsp_ready;
      s1f = !m_s1v || s2f;
`ifdef ADD_ARB_RR_EN
      start = m_ptr;
`else
      start = 0;
`endif
      g = s1f ? pick(vm, start) : -1;
      expr = '0;
      if (g >= 0) expr[g] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(expr));
      if (s2f) m_s2v = m_s1v;
      if (g >= 0) begin
        e.sum = {1'b0, pa[g]} + {1'b0, pb[g]};
        e.id  = g;
        exp_q.push_back(e);
        m_s1v = 1;
        m_ptr = (g + 1) % NREQ;
      end else if (s1f) begin
        m_s1v = 0;
      end
      last_gnt = g;
    end
    @(posedge clk);
    #1;
    if (last_gnt >= 0) pv[last_gnt] = 0;
  endtask

  task automatic arm(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    pv[i] = 1; pa[i] = a; pb[i] = b;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: pops the scoreboard on each response transfer and checks stall stability.
  bit         held_v = 0;
  logic [W:0] held_sum;
  logic [IDW-1:0] held_id;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (held_v) begin
          check("hold_valid", 64'(rsp_valid), 64'(1));
          check("hold_sum", 64'(rsp_sum), 64'(held_sum));
          check("hold_id", 64'(rsp_id), 64'(held_id));
        end
        held_v = 0;
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("rsp_sum", 64'(rsp_sum), 64'(e.sum));
            check("rsp_id", 64'(rsp_id), 64'(e.id));
          end
        end else if (rsp_valid) begin
          held_v = 1; held_sum = rsp_sum; held_id = rsp_id;
        end
      end else begin
        held_v = 0;
      end
    end
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin pv[i] = 0; pa[i] = '0; pb[i] = '0; end
    rst = 1; rsp_ready = 1; apply();
    @(posedge clk); #1;
    arm(0, 16'h5555, 16'h1111); apply();
    step();
    rst = 0; pv[0] = 0; apply();
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_sum", 64'(rsp_sum), 64'(0));
    check("reset_rsp_id", 64'(rsp_id), 64'(0));

    // Single transfer, two-cycle latency
    arm(0, 16'h1234, 16'h0001); apply();
    step();
    check("single_grant", 64'(dut_gnt), 64'(0));
    apply();
    for (int c = 0; c < 3; c++) step();

    // Carry out of the top bit
    arm(2, 16'hFFFF, 16'hFFFF); apply();
    step();
    check("carry_grant", 64'(dut_gnt), 64'(2));
    apply();
    for (int c = 0; c < 3; c++) step();

    // All requesters valid for 8 cycles from a fresh reset
    rst = 1; apply(); step(); rst = 0;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < NREQ; i++) if (!pv[i]) arm(i, rnd_op(), rnd_op());
      apply();
      step();
`ifdef ADD_ARB_RR_EN
      check("allvalid_grant", 64'(dut_gnt), 64'(c % NREQ));
`else
      check("allvalid_grant", 64'(dut_gnt), 64'(0));
`endif
    end
    for (int i = 0; i < NREQ; i++) pv[i] = 0;
    apply();
    for (int c = 0; c < 3; c++) step();

    // Backpressure: consumer stalls for 3 cycles after first result
    for (int i = 0; i < NREQ; i++) arm(i, rnd_op(), rnd_op());
    for (int c = 0; c < 12; c++) begin
      rsp_ready = !(c >= 3 && c <= 5);
      apply();
      step();
      if (c == 5) check("bp_ready_zero", 64'(req_ready), 64'(0));
    end

    // Reset with both stages full
    rsp_ready = 0;
    for (int i = 0; i < NREQ; i++) arm(i, rnd_op(), rnd_op());
    for (int c = 0; c < 3; c++) begin apply(); step(); end
    for (int i = 0; i < NREQ; i++) if (!pv[i]) arm(i, rnd_op(), rnd_op());
    rst = 1; apply(); step();
    rst = 0; rsp_ready = 1;
    check("rstfull_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rstfull_rsp_sum", 64'(rsp_sum), 64'(0));
    apply(); step();
    check("rstfull_grant", 64'(dut_gnt), 64'(0));

    // Random traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && ($urandom_range(0, 2) == 0)) arm(i, rnd_op(), rnd_op());
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      apply();
      step();
    end

    for (int i = 0; i < NREQ; i++) pv[i] = 0;
    rsp_ready = 1;
    apply();
    for (int c = 0; c < 4; c++) step();
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
